sdram_readback_checker: RTL and testbench
=========================================

Name: sdram_readback_checker

Overview:
- Downstream companion to the SDRAM test-pattern writer: once the writer finishes, this block reads back the same word range over the Avalon-MM read master port and checks every returned word against the expected pattern.
- Reports pass/fail, a saturating error count, and the first failing address and data.
- Sits between the top-level test sequencer and the SDRAM controller read port.

Parameters:
- N_WORDS, 400, number of 16-bit words checked, at word addresses BASE_ADDR .. BASE_ADDR+N_WORDS-1; legal range 1..512.
- BASE_ADDR, 25'd0, first word address.
- MAX_OUTSTANDING, 4, maximum accepted reads still awaiting data; legal range 1..15.

Ports:
- iCLK  in  1  system clock; all logic on the rising edge.
- iRST_N  in  1  asynchronous active-low reset.
- iSTART  in  1  level start; a high level in IDLE launches a check run.
- iWAIT_REQUEST  in  1  controller stall; a request is accepted on a cycle with oRD_EN=1 and iWAIT_REQUEST=0.
- iRD_DATA  in  16  read data, valid when iRD_DATAVALID=1; returned in request order.
- iRD_DATAVALID  in  1  read-data strobe.
- oRD_EN  out  1  read request.
- oRD_ADDR  out  25  word address of the current request.
- oBUSY  out  1  high in REQ and DRAIN.
- oDONE  out  1  high only in DONE.
- oPASS  out  1  valid when oDONE=1; high when oERR_CNT=0.
- oERR_CNT  out  10  mismatching words; saturates at 1023.
- oFIRST_ERR_ADDR  out  25  address of the first mismatch; 0 if none.
- oFIRST_ERR_DATA  out  16  data received at the first mismatch; 0 if none.

Behaviour:
- Expected word at word address a: upper byte {a[6:3], ~a[2], a[1:0], 1'b0}, lower byte {a[6:3], ~a[2], a[1:0], 1'b1}.
  - a=0 gives 16'h0809; a=5 gives 16'h0203; a=399 gives 16'h1617.
- Reset: while iRST_N=0, all registers clear immediately.
  - State is IDLE.
  - All outputs are 0, including oPASS.
  - oRD_ADDR is BASE_ADDR.
- State machine, registered, one transition per cycle:
  - IDLE: iSTART=1 moves to REQ; clears request index, response index, outstanding count, error count and first-error registers.
  - REQ: oRD_EN=1 whenever request index < N_WORDS and outstanding < MAX_OUTSTANDING. oRD_ADDR = BASE_ADDR + request index.
    - When oRD_EN is asserted and stalled, oRD_EN and oRD_ADDR hold unchanged until accepted.
    - On acceptance the request index increments.
    - The cycle the last request is accepted, move to DRAIN.
  - DRAIN: oRD_EN=0; wait until the response index reaches N_WORDS, then move to DONE.
  - DONE: all results hold stable; iSTART=0 returns to IDLE.
- Outstanding counter:
  - +1 on acceptance, -1 on iRD_DATAVALID.
  - Both in the same cycle leaves it unchanged.
  - MAX_OUTSTANDING is reached only through acceptance; once at the maximum, oRD_EN is not raised again until a response arrives.
- Response path:
  - Each iRD_DATAVALID in REQ or DRAIN compares iRD_DATA with pattern(BASE_ADDR + response index), then increments the response index.
  - On mismatch, oERR_CNT increments (saturating). If it was 0, oFIRST_ERR_ADDR and oFIRST_ERR_DATA capture the address and iRD_DATA.
- Latency: oDONE rises exactly one cycle after the cycle carrying the last iRD_DATAVALID.
  - Case N_WORDS=1: REQ, then DRAIN, then DONE.
- Boundary conditions:
  - iRD_DATAVALID in IDLE or DONE is ignored and has no effect on any counter.
  - iSTART dropping mid-run does not abort; the run completes and DONE exits immediately on the next cycle.
  - iSTART held high in DONE keeps DONE; results stay readable.
  - Asserting iRST_N=0 mid-run aborts at once; outstanding responses arriving after release land in IDLE and are ignored.
- Widths:
  - Request and response indices are 10 bits, so they count to 512 without wrap.
  - Address sum is 25 bits, zero-extended.

Decomposition:
- Shared package sdram_test_pkg holds:
  - the state encodings;
  - a pattern function (25-bit word address in, 16-bit word out), also used by the writer so the two blocks cannot disagree;
  - the N_WORDS default.
- No sub-module; the single block is ~200 lines.

Test Plan:
- Zero-wait model returning correct pattern, 2-cycle read latency, N_WORDS=400, iSTART held high → 400 acceptances; oDONE=1 one cycle after the 400th valid; oPASS=1; oERR_CNT=0; first-error outputs 0.
- Memory model flips bit 0 at addresses 5 and 300 → oERR_CNT=2; oFIRST_ERR_ADDR=5; oFIRST_ERR_DATA=16'h0202; oPASS=0.
- iWAIT_REQUEST high for 3 cycles while oRD_ADDR=7 → oRD_EN stays 1 and oRD_ADDR stays 7 throughout; address 8 is issued only after acceptance; no address skipped or duplicated.
- Read latency 10 cycles, MAX_OUTSTANDING=4 → outstanding count never exceeds 4; oRD_EN drops after the 4th acceptance until the first valid arrives.
- iSTART deasserted at cycle 50 mid-run → run completes; oDONE pulses for exactly 1 cycle; state returns to IDLE. Re-raising iSTART → full second run with counters cleared.
- iRST_N low mid-run with 3 reads outstanding, 3 late valids after release → outputs 0 immediately; late valids ignored; oERR_CNT remains 0.

Source files
------------

// File: rtl/sdram_test_pkg.sv
// Shared definitions for the SDRAM test-pattern writer and readback checker.
// Both blocks take the expected data word from patternWord() so they cannot
// drift apart.
package sdram_test_pkg;

    localparam int ADDR_W          = 25;
    localparam int DATA_W          = 16;
    localparam int IDX_W           = 10;
    localparam int ERR_W           = 10;
    localparam int OUT_W           = 4;
    localparam int N_WORDS_DEFAULT = 400;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_t;

    // Both bytes carry the same address tag; the low bit tells the bytes apart
    // so a byte-lane swap shows up as a mismatch.
    function automatic logic [DATA_W-1:0] patternWord(input logic [ADDR_W-1:0] addr);
        logic [7:0] tag;
        tag = {addr[6:3], ~addr[2], addr[1:0], 1'b0};
        return {tag, tag | 8'h01};
    endfunction

endpackage

// File: rtl/sdram_readback_checker_if.sv
// Avalon-MM read-master bus between the readback checker and the SDRAM
// controller read port.
interface sdram_readback_checker_if;
    import sdram_test_pkg::*;

    logic              rdEn;
    logic [ADDR_W-1:0] rdAddr;
    logic              waitRequest;
    logic [DATA_W-1:0] rdData;
    logic              rdDataValid;

    modport master (
        output rdEn,
        output rdAddr,
        input  waitRequest,
        input  rdData,
        input  rdDataValid
    );

    modport slave (
        input  rdEn,
        input  rdAddr,
        output waitRequest,
        output rdData,
        output rdDataValid
    );

endinterface

// File: rtl/sdram_readback_checker.sv
// Reads back BASE_ADDR .. BASE_ADDR+N_WORDS-1 with up to MAX_OUTSTANDING
// pipelined reads in flight and checks every returned word against the
// shared test pattern.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for iSTART; run counters cleared on launch
//   ST_REQ   | issuing reads (throttled by outstanding count), checking data
//   ST_DRAIN | all reads accepted, checking the remaining responses
//   ST_DONE  | results stable; leaves when iSTART drops
module sdram_readback_checker
    import sdram_test_pkg::*;
#(
    parameter int                N_WORDS         = N_WORDS_DEFAULT,
    parameter logic [ADDR_W-1:0] BASE_ADDR       = '0,
    parameter int                MAX_OUTSTANDING = 4
) (
    input  logic                     iCLK,
    input  logic                     iRST_N,
    input  logic                     iSTART,
    sdram_readback_checker_if.master rdBus,
    output logic                     oBUSY,
    output logic                     oDONE,
    output logic                     oPASS,
    output logic [ERR_W-1:0]         oERR_CNT,
    output logic [ADDR_W-1:0]        oFIRST_ERR_ADDR,
    output logic [DATA_W-1:0]        oFIRST_ERR_DATA
);

    localparam logic [IDX_W-1:0] WORD_CNT = IDX_W'(N_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);
    localparam logic [OUT_W-1:0] MAX_OUT  = OUT_W'(MAX_OUTSTANDING);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    chk_state_t        state;
    chk_state_t        stateNext;
    logic [IDX_W-1:0]  reqIdx;
    logic [IDX_W-1:0]  rspIdx;
    logic [OUT_W-1:0]  outCnt;
    logic [ERR_W-1:0]  errCnt;
    logic [ADDR_W-1:0] firstErrAddr;
    logic [DATA_W-1:0] firstErrData;
    logic [ADDR_W-1:0] rspAddr;
    logic              runClear;
    logic              rdEn;
    logic              accept;
    logic              rspFire;
    logic              rspMismatch;

    // Responses only count while a run is active; strays in IDLE/DONE are dropped.
    assign rspFire     = rdBus.rdDataValid && ((state == ST_REQ) || (state == ST_DRAIN));
    assign rspAddr     = BASE_ADDR + {{(ADDR_W-IDX_W){1'b0}}, rspIdx};
    assign rspMismatch = rspFire && (rdBus.rdData != patternWord(rspAddr));
    assign accept      = rdEn && !rdBus.waitRequest;

    assign rdBus.rdEn   = rdEn;
    assign rdBus.rdAddr = BASE_ADDR + {{(ADDR_W-IDX_W){1'b0}}, reqIdx};

    assign oERR_CNT        = errCnt;
    assign oFIRST_ERR_ADDR = firstErrAddr;
    assign oFIRST_ERR_DATA = firstErrData;
    assign oPASS           = oDONE && (errCnt == '0);

    // State register.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and request/status decode. rdEn depends only on registered
    // index and count, so a stalled request holds its address until accepted.
    always_comb begin
        stateNext = state;
        runClear  = 1'b0;
        rdEn      = 1'b0;
        oBUSY     = 1'b0;
        oDONE     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (iSTART) begin
                    stateNext = ST_REQ;
                    runClear  = 1'b1;
                end
            end
            ST_REQ: begin
                oBUSY = 1'b1;
                rdEn  = (reqIdx < WORD_CNT) && (outCnt < MAX_OUT);
                if (rdEn && !rdBus.waitRequest && (reqIdx == LAST_IDX)) begin
                    stateNext = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                oBUSY = 1'b1;
                // Leave on the cycle of the final response so DONE follows it directly.
                if ((rspIdx == WORD_CNT) || (rspFire && (rspIdx == LAST_IDX))) begin
                    stateNext = ST_DONE;
                end
            end
            ST_DONE: begin
                oDONE = 1'b1;
                if (!iSTART) begin
                    stateNext = ST_IDLE;
                end
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    // Request and response indices.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            reqIdx <= '0;
            rspIdx <= '0;
        end else if (runClear) begin
            reqIdx <= '0;
            rspIdx <= '0;
        end else begin
            if (accept) begin
                reqIdx <= reqIdx + 1'b1;
            end
            if (rspFire) begin
                rspIdx <= rspIdx + 1'b1;
            end
        end
    end

    // Reads in flight: up on acceptance, down on returned data.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            outCnt <= '0;
        end else if (runClear) begin
            outCnt <= '0;
        end else begin
            case ({accept, rspFire})
                2'b10:   outCnt <= outCnt + 1'b1;
                2'b01:   outCnt <= outCnt - 1'b1;
                default: outCnt <= outCnt;
            endcase
        end
    end

    // Saturating error count; the first mismatch also latches address and data.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            errCnt       <= '0;
            firstErrAddr <= '0;
            firstErrData <= '0;
        end else if (runClear) begin
            errCnt       <= '0;
            firstErrAddr <= '0;
            firstErrData <= '0;
        end else if (rspMismatch) begin
            if (errCnt != ERR_MAX) begin
                errCnt <= errCnt + 1'b1;
            end
            if (errCnt == '0) begin
                firstErrAddr <= rspAddr;
                firstErrData <= rdBus.rdData;
            end
        end
    end

endmodule

// File: tb/tb_sdram_readback_checker.sv
// Bench for sdram_readback_checker: a randomised Avalon read slave with
// in-order latency and injectable bit errors, an address scoreboard fed at
// launch and drained on every acceptance, and a result scoreboard popped by
// a monitor whenever oDONE rises.
module tb_sdram_readback_checker;
    import sdram_test_pkg::*;

    localparam int                N    = 400;
    localparam logic [ADDR_W-1:0] BASE = '0;
    localparam int                MAXO = 4;

    typedef struct {
        int addr;
        int due;
        bit stale;
    } rsp_t;

    typedef struct {
        int errCnt;
        int firstAddr;
        int firstData;
        bit pass;
    } res_t;

    logic              iCLK   = 1'b0;
    logic              iRST_N = 1'b0;
    logic              iSTART = 1'b0;
    logic              oBUSY;
    logic              oDONE;
    logic              oPASS;
    logic [ERR_W-1:0]  oERR_CNT;
    logic [ADDR_W-1:0] oFIRST_ERR_ADDR;
    logic [DATA_W-1:0] oFIRST_ERR_DATA;

    sdram_readback_checker_if bus ();

    sdram_readback_checker #(
        .N_WORDS         (N),
        .BASE_ADDR       (BASE),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .iCLK            (iCLK),
        .iRST_N          (iRST_N),
        .iSTART          (iSTART),
        .rdBus           (bus),
        .oBUSY           (oBUSY),
        .oDONE           (oDONE),
        .oPASS           (oPASS),
        .oERR_CNT        (oERR_CNT),
        .oFIRST_ERR_ADDR (oFIRST_ERR_ADDR),
        .oFIRST_ERR_DATA (oFIRST_ERR_DATA)
    );

    always #5 iCLK = ~iCLK;

    int   nVec = 0;
    int   nMis = 0;
    int   cyc  = 0;
    rsp_t rspQ[$];
    int   expAddrQ[$];
    res_t expResQ[$];
    logic [15:0] corrupt [N];
    int   latMin = 2, latMax = 2, waitPct = 0;
    int   stallAddr = -1;
    bit   stallArmed = 1'b0;
    int   stallCnt = 0;
    int   issued = 0, outCnt = 0, rspCnt = 0, lastValidCyc = -1, lastDue = 0;
    bit   prevDone = 1'b0;

    // Expected word from the written-down rule: tag = a[6:3], inverted a[2], a[1:0], 0.
    function automatic logic [15:0] expWord(input int a);
        int tag;
        tag = ((a / 8) % 16) * 16 + (1 - ((a / 4) % 2)) * 8 + (a % 4) * 2;
        return 16'(tag * 256 + tag + 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkQuiet(input string tag);
        check({tag, "_rd_en"},      32'(bus.rdEn), 0);
        check({tag, "_rd_addr"},    32'(bus.rdAddr), 32'(BASE));
        check({tag, "_busy"},       32'(oBUSY), 0);
        check({tag, "_done"},       32'(oDONE), 0);
        check({tag, "_pass"},       32'(oPASS), 0);
        check({tag, "_err_cnt"},    32'(oERR_CNT), 0);
        check({tag, "_first_addr"}, 32'(oFIRST_ERR_ADDR), 0);
        check({tag, "_first_data"}, 32'(oFIRST_ERR_DATA), 0);
    endtask

    // Read slave: random wait states, optional scripted stall, in-order data.
    always @(negedge iCLK) begin
        rsp_t r;
        bit   wr;
        int   due;
        cyc++;
        wr = 1'b0;
        bus.rdDataValid = 1'b0;
        bus.rdData      = '0;
        if (!iRST_N) begin
            foreach (rspQ[i]) rspQ[i].stale = 1'b1;
            expAddrQ.delete();
            issued   = 0;
            outCnt   = 0;
            rspCnt   = 0;
            stallCnt = 0;
        end else begin
            check("rd_en", 32'(bus.rdEn), 32'(oBUSY && (issued < N) && (outCnt < MAXO)));
            if (stallCnt > 0) begin
                wr = 1'b1;
                stallCnt--;
                check("stall_hold_en", 32'(bus.rdEn), 1);
                check("stall_hold_addr", 32'(bus.rdAddr), 32'(stallAddr));
            end else if (stallArmed && bus.rdEn && (int'(bus.rdAddr) == stallAddr)) begin
                stallArmed = 1'b0;
                wr = 1'b1;
                stallCnt = 2;
            end else begin
                wr = ($urandom_range(99) < waitPct);
            end
        end
        if ((rspQ.size() > 0) && (rspQ[0].due <= cyc)) begin
            r = rspQ.pop_front();
            bus.rdDataValid = 1'b1;
            if (r.stale) begin
                bus.rdData = ~expWord(r.addr);
            end else begin
                bus.rdData = expWord(r.addr) ^ corrupt[r.addr - int'(BASE)];
                outCnt--;
                rspCnt++;
                if (rspCnt == N) lastValidCyc = cyc;
            end
        end
        bus.waitRequest = wr;
        if (iRST_N && bus.rdEn && !wr) begin
            issued++;
            outCnt++;
            check("outstanding_le_max", 32'(outCnt <= MAXO), 1);
            if (expAddrQ.size() == 0) begin
                nVec++;
                nMis++;
                $display("FAIL extra_request: got addr %0d, expected no request", bus.rdAddr);
            end else begin
                check("req_addr", 32'(bus.rdAddr), 32'(expAddrQ.pop_front()));
            end
            due = cyc + int'($urandom_range(latMax, latMin));
            if (due <= lastDue) due = lastDue + 1;
            lastDue = due;
            rspQ.push_back('{addr: int'(bus.rdAddr), due: due, stale: 1'b0});
        end
    end

    // Result monitor: each oDONE rise retires one expected run result.
    always @(posedge iCLK) begin
        res_t e;
        #1;
        if (iRST_N && oDONE && !prevDone) begin
            if (expResQ.size() == 0) begin
                nVec++;
                nMis++;
                $display("FAIL unexpected_done: got oDONE=1, expected no run pending");
            end else begin
                e = expResQ.pop_front();
                check("done_latency", 32'(cyc), 32'(lastValidCyc));
                check("responses", 32'(rspCnt), N);
                check("addr_queue_empty", 32'(expAddrQ.size()), 0);
                check("err_cnt", 32'(oERR_CNT), 32'(e.errCnt));
                check("first_err_addr", 32'(oFIRST_ERR_ADDR), 32'(e.firstAddr));
                check("first_err_data", 32'(oFIRST_ERR_DATA), 32'(e.firstData));
                check("pass", 32'(oPASS), 32'(e.pass));
            end
        end
        prevDone = oDONE;
    end

    task automatic setRun(input int lmin, input int lmax, input int wp);
        latMin  = lmin;
        latMax  = lmax;
        waitPct = wp;
    endtask

    task automatic clearCorrupt();
        for (int i = 0; i < N; i++) corrupt[i] = '0;
    endtask

    // Reference model for one run, pushed before iSTART is raised.
    task automatic launch(output res_t e);
        int errs;
        errs = 0;
        e = '{errCnt: 0, firstAddr: 0, firstData: 0, pass: 1'b0};
        issued = 0;
        rspCnt = 0;
        lastValidCyc = -1;
        for (int a = 0; a < N; a++) begin
            expAddrQ.push_back(int'(BASE) + a);
            if (corrupt[a] != 0) begin
                if (errs == 0) begin
                    e.firstAddr = int'(BASE) + a;
                    e.firstData = int'(expWord(int'(BASE) + a) ^ corrupt[a]);
                end
                errs = (errs < 1023) ? errs + 1 : 1023;
            end
        end
        e.errCnt = errs;
        e.pass   = (errs == 0);
        expResQ.push_back(e);
        @(negedge iCLK);
        #1 iSTART = 1'b1;
    endtask

    task automatic waitDone(input string tag, input int maxCyc);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < maxCyc; k++) begin
            @(posedge iCLK);
            #1;
            if (oDONE) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_reached"}, 32'(seen), 1);
        if (!seen) begin
            $display("FAIL %s_timeout: oDONE not seen within %0d cycles", tag, maxCyc);
            $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
            $fatal(1, "run timed out");
        end
    endtask

    task automatic holdAndRelease(input string tag, input res_t e);
        repeat (5) @(posedge iCLK);
        #1;
        check({tag, "_done_held"}, 32'(oDONE), 1);
        check({tag, "_err_cnt_held"}, 32'(oERR_CNT), 32'(e.errCnt));
        check({tag, "_pass_held"}, 32'(oPASS), 32'(e.pass));
        check({tag, "_accepts"}, 32'(issued), N);
        @(negedge iCLK);
        #1 iSTART = 1'b0;
        @(posedge iCLK);
        #1;
        check({tag, "_done_exit"}, 32'(oDONE), 0);
        check({tag, "_idle_busy"}, 32'(oBUSY), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t e;
        int   idx;
        bit   reached;
        clearCorrupt();
        #2;
        checkQuiet("reset");
        repeat (3) @(negedge iCLK);
        #1 iRST_N = 1'b1;
        repeat (2) @(posedge iCLK);

        // Clean run, zero wait, latency 2, start held.
        setRun(2, 2, 0);
        launch(e);
        waitDone("clean", 3000);
        holdAndRelease("clean", e);

        // Bit-0 errors at 5 and 300, 3-cycle stall on address 7.
        clearCorrupt();
        corrupt[5]   = 16'h0001;
        corrupt[300] = 16'h0001;
        stallAddr    = 7;
        stallArmed   = 1'b1;
        launch(e);
        waitDone("errs", 3000);
        check("errs_stall_used", 32'(stallArmed), 0);
        holdAndRelease("errs", e);

        // Latency 10 with random waits and random corruption; start dropped mid-run.
        clearCorrupt();
        for (int k = 0; k < 3; k++) begin
            idx = int'($urandom_range(N - 1));
            corrupt[idx] = 16'($urandom_range(65535, 1));
        end
        setRun(10, 10, 20);
        launch(e);
        repeat (50) @(posedge iCLK);
        @(negedge iCLK);
        #1 iSTART = 1'b0;
        check("drop_still_busy", 32'(oBUSY), 1);
        waitDone("drop", 6000);
        @(posedge iCLK);
        #1;
        check("drop_done_pulse", 32'(oDONE), 0);
        check("drop_idle_busy", 32'(oBUSY), 0);

        // Second run after an erroring run: counters must start clean.
        clearCorrupt();
        setRun(1, 6, 30);
        launch(e);
        waitDone("rerun", 6000);
        holdAndRelease("rerun", e);

        // Reset with three reads in flight; their late data must be ignored.
        setRun(10, 10, 0);
        launch(e);
        reached = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge iCLK);
            #1;
            if (outCnt == 3) begin
                reached = 1'b1;
                break;
            end
        end
        check("rst_three_outstanding", 32'(reached), 1);
        iRST_N = 1'b0;
        iSTART = 1'b0;
        #1;
        checkQuiet("midrst");
        expResQ.delete();
        repeat (2) @(negedge iCLK);
        #1 iRST_N = 1'b1;
        repeat (15) @(posedge iCLK);
        #1;
        check("late_rsp_queue_drained", 32'(rspQ.size()), 0);
        checkQuiet("late_valids");

        // Full run after the reset.
        setRun(3, 3, 10);
        launch(e);
        waitDone("post_rst", 4000);
        holdAndRelease("post_rst", e);

        repeat (3) @(posedge iCLK);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
